// File: rtl/boa_mem_arb_pkg.sv
// Shared types and helpers for the boa memory bus two-master arbiter.
package boa_mem_arb_pkg;

  typedef logic [0:0] arb_sel_t;

  // Width needed to count 0..burst_max inclusive.
  function automatic int cnt_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// boa memory bus: CPU side drives the request, MEM side answers with ready/rdata.
interface boa_mem_bus;
  logic        re;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport MEM (input re, we, addr, wdata, output rdata, ready);
  modport CPU (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/boa_mem_arb_grant.sv
// Combinational grant decision for the two-master arbiter.
// Build option: BOA_MEM_ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
module boa_mem_arb_grant
  import boa_mem_arb_pkg::*;
#(
  parameter int CNT_W     = 3,
  parameter int BURST_MAX = 4
) (
  input  logic             req0,
  input  logic             req1,
  input  arb_sel_t         owner,
  input  logic [CNT_W-1:0] cnt,
  input  logic             lock,
  output logic             grant_valid,
  output arb_sel_t         grant
);

`ifdef BOA_MEM_ARB_FIXED_PRIO_EN
  // Burst counting has no influence on a fixed-priority contest.
  logic unused_cnt;
  assign unused_cnt = ^cnt;
`else
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant       = owner;
    if (lock) begin
      // A stalled transfer keeps the bus until the slave accepts it.
      grant_valid = 1'b1;
      grant       = owner;
    end else if (req0 && !req1) begin
      grant_valid = 1'b1;
      grant       = 1'b0;
    end else if (req1 && !req0) begin
      grant_valid = 1'b1;
      grant       = 1'b1;
    end else if (req0 && req1) begin
      grant_valid = 1'b1;
`ifdef BOA_MEM_ARB_FIXED_PRIO_EN
      grant       = 1'b0;
`else
      grant       = (cnt < CNT_MAX) ? owner : ~owner;
`endif
    end
  end

endmodule

// File: rtl/boa_mem_arbiter.sv
// Two-master to one-slave boa memory bus arbiter: round-robin with bounded bursts,
// grant locking across stalls, and read-data routing. Option: BOA_MEM_ARB_FIXED_PRIO_EN.
module boa_mem_arbiter
  import boa_mem_arb_pkg::*;
#(
  parameter int burst_max = 4
) (
  input  logic    clk,
  input  logic    rst,
  boa_mem_bus.MEM m0,
  boa_mem_bus.MEM m1,
  boa_mem_bus.CPU mem
);

  localparam int CNT_W = cnt_width(burst_max);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(burst_max);

  logic             req0, req1;
  logic             grant_valid;
  arb_sel_t         grant;
  arb_sel_t         owner_q, owner_d;
  arb_sel_t         resp_sel_q, resp_sel_d;
  arb_sel_t         fwd_sel;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fwd_re;
  logic [3:0]       fwd_we;
  logic             drive_ok;

  assign req0 = m0.re | (|m0.we);
  assign req1 = m1.re | (|m1.we);

  boa_mem_arb_grant #(
    .CNT_W     (CNT_W),
    .BURST_MAX (burst_max)
  ) u_grant (
    .req0        (req0),
    .req1        (req1),
    .owner       (owner_q),
    .cnt         (cnt_q),
    .lock        (lock_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // With no grant the address/data lines stay parked on the last owner.
  assign fwd_sel  = grant_valid ? grant : owner_q;
  assign fwd_re   = fwd_sel[0] ? m1.re : m0.re;
  assign fwd_we   = fwd_sel[0] ? m1.we : m0.we;
  assign drive_ok = grant_valid & ~rst;

  assign mem.re    = drive_ok & fwd_re;
  assign mem.we    = drive_ok ? fwd_we : 4'h0;
  assign mem.addr  = fwd_sel[0] ? m1.addr  : m0.addr;
  assign mem.wdata = fwd_sel[0] ? m1.wdata : m0.wdata;

  assign m0.ready = drive_ok & (grant == 1'b0) & mem.ready;
  assign m1.ready = drive_ok & (grant == 1'b1) & mem.ready;

  assign m0.rdata = (!rst && resp_sel_q == 1'b0) ? mem.rdata : 32'h0;
  assign m1.rdata = (!rst && resp_sel_q == 1'b1) ? mem.rdata : 32'h0;

  always_comb begin
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    resp_sel_d = resp_sel_q;
    if (grant_valid) begin
      owner_d = grant;
      if (mem.ready) begin
        if (grant == owner_q) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cnt_d = CNT_W'(1);
        end
        lock_d = 1'b0;
        if (fwd_re) begin
          resp_sel_d = grant;
        end
      end else begin
        lock_d = 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      resp_sel_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      resp_sel_q <= resp_sel_d;
    end
  end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Directed bench for boa_mem_arbiter: expected accepts are queued as stimulus is driven
// and popped by a monitor. Honours BOA_MEM_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_boa_mem_arbiter;

  logic clk;
  logic rst;

  boa_mem_bus m0_bus ();
  boa_mem_bus m1_bus ();
  boa_mem_bus mem_bus ();

  boa_mem_arbiter #(.burst_max(4)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .mem (mem_bus)
  );

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic [3:0]  we;
  } acc_t;

  acc_t        acc_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] a0, a1, e0, e1;
  logic        pend_v = 1'b0;
  logic        pend_m;
  logic [31:0] pend_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ addr;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave model: always ready unless the stimulus stalls it, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_bus.re && mem_bus.ready) mem_bus.rdata <= pat(mem_bus.addr);
  end

  // Monitor: checks each accepted transfer against the queue and its read data a cycle later.
  always @(negedge clk) begin
    if (rst) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        chk("rdata_m0", m0_bus.rdata, (pend_m == 1'b0) ? pend_d : 32'h0);
        chk("rdata_m1", m1_bus.rdata, (pend_m == 1'b1) ? pend_d : 32'h0);
        $display("resp  master=%0d rdata=%h", pend_m, pend_m ? m1_bus.rdata : m0_bus.rdata);
        pend_v = 1'b0;
      end
      if (m0_bus.ready || m1_bus.ready) begin
        chk("ready_both", {31'h0, m0_bus.ready & m1_bus.ready}, 32'h0);
        if (acc_q.size() == 0) begin
          chk("accept_extra", {31'h0, m1_bus.ready}, 32'hFFFF_FFFF);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          $display("accept master=%0d addr=%h we=%h", m1_bus.ready, mem_bus.addr, mem_bus.we);
          chk("accept_master", {31'h0, m1_bus.ready}, {31'h0, e.m});
          chk("accept_addr", mem_bus.addr, e.addr);
          chk("accept_we", {28'h0, mem_bus.we}, {28'h0, e.we});
          if (e.we == 4'h0) begin
            pend_v = 1'b1;
            pend_m = e.m;
            pend_d = pat(e.addr);
          end
        end
      end
    end
  end

  task automatic push_rd(input logic m);
    acc_t e;
    e.m  = m;
    e.we = 4'h0;
    if (m == 1'b0) begin
      e.addr = e0;
      e0 = e0 + 32'd4;
    end else begin
      e.addr = e1;
      e1 = e1 + 32'd4;
    end
    acc_q.push_back(e);
  endtask

  task automatic push_wr(input logic m, input logic [31:0] addr);
    acc_t e;
    e.m    = m;
    e.addr = addr;
    e.we   = 4'hF;
    acc_q.push_back(e);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    to_pos();
  endtask

  // Masters issue back-to-back reads, advancing their address on each accept.
  task automatic run(input int n, input logic r0, input logic r1);
    for (int i = 0; i < n; i++) begin
      m0_bus.re   = r0;
      m0_bus.addr = a0;
      m1_bus.re   = r1;
      m1_bus.addr = a1;
      @(negedge clk);
      chk("one_accept", 32'(int'(m0_bus.ready) + int'(m1_bus.ready)), 32'd1);
      if (m0_bus.ready) a0 = a0 + 32'd4;
      if (m1_bus.ready) a1 = a1 + 32'd4;
      to_pos();
    end
    m0_bus.re = 1'b0;
    m1_bus.re = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    m0_bus.re     = 1'b1;
    m0_bus.we     = 4'h0;
    m0_bus.addr   = 32'h10;
    m0_bus.wdata  = 32'h0;
    m1_bus.re     = 1'b0;
    m1_bus.we     = 4'h0;
    m1_bus.addr   = 32'h0;
    m1_bus.wdata  = 32'h0;
    mem_bus.ready = 1'b1;
    a0 = 32'h100; e0 = 32'h100;
    a1 = 32'h200; e1 = 32'h200;

    // Reset holds everything quiet even with m0 requesting.
    @(negedge clk);
    chk("rst_mem_re", {31'h0, mem_bus.re}, 32'h0);
    chk("rst_mem_we", {28'h0, mem_bus.we}, 32'h0);
    chk("rst_m0_ready", {31'h0, m0_bus.ready}, 32'h0);
    chk("rst_m1_ready", {31'h0, m1_bus.ready}, 32'h0);
    chk("rst_m0_rdata", m0_bus.rdata, 32'h0);
    chk("rst_m1_rdata", m1_bus.rdata, 32'h0);
    to_pos();
    rst = 1'b0;
    acc_q.push_back('{m: 1'b0, addr: 32'h10, we: 4'h0});
    @(negedge clk);
    chk("post_rst_addr", mem_bus.addr, 32'h10);
    chk("post_rst_ready", {31'h0, m0_bus.ready}, 32'h1);
    to_pos();
    m0_bus.re = 1'b0;
    idle();

    // Contention: bursts of four alternate between masters without bubbles.
    for (int k = 0; k < 12; k++) begin
`ifdef BOA_MEM_ARB_FIXED_PRIO_EN
      push_rd(1'b0);
`else
      push_rd(((k / 4) % 2) == 1);
`endif
    end
    run(12, 1'b1, 1'b1);
    push_rd(1'b1);
    run(1, 1'b0, 1'b1);
    idle();

    // Stalled m1 write keeps the bus while m0 waits.
    mem_bus.ready = 1'b0;
    m1_bus.we     = 4'hF;
    m1_bus.addr   = 32'h20;
    m1_bus.wdata  = 32'hDEAD_BEEF;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin
        m0_bus.re   = 1'b1;
        m0_bus.addr = 32'h30;
      end
      @(negedge clk);
      chk("stall_we", {28'h0, mem_bus.we}, 32'hF);
      chk("stall_addr", mem_bus.addr, 32'h20);
      chk("stall_wdata", mem_bus.wdata, 32'hDEAD_BEEF);
      chk("stall_m0_ready", {31'h0, m0_bus.ready}, 32'h0);
      to_pos();
    end
    mem_bus.ready = 1'b1;
    push_wr(1'b1, 32'h20);
    acc_q.push_back('{m: 1'b0, addr: 32'h30, we: 4'h0});
    @(negedge clk);
    chk("stall_release_m1", {31'h0, m1_bus.ready}, 32'h1);
    to_pos();
    m1_bus.we = 4'h0;
    @(negedge clk);
    chk("after_stall_m0", {31'h0, m0_bus.ready}, 32'h1);
    to_pos();
    m0_bus.re = 1'b0;
    idle();

    // An idle cycle clears the burst count, so m0 earns a fresh burst.
    a0 = 32'h400; e0 = 32'h400;
    for (int k = 0; k < 3; k++) push_rd(1'b0);
    run(3, 1'b1, 1'b0);
    idle();
    for (int k = 0; k < 5; k++) begin
`ifdef BOA_MEM_ARB_FIXED_PRIO_EN
      push_rd(1'b0);
`else
      push_rd(k == 4);
`endif
    end
    run(5, 1'b1, 1'b1);
    idle();

    // Reset during a stalled m1 write drops it at once; m0 wins afterwards.
    mem_bus.ready = 1'b0;
    m1_bus.we     = 4'hF;
    m1_bus.addr   = 32'h24;
    m1_bus.wdata  = 32'h1234_5678;
    @(negedge clk);
    chk("pre_rst_we", {28'h0, mem_bus.we}, 32'hF);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_we", {28'h0, mem_bus.we}, 32'h0);
    chk("midrst_re", {31'h0, mem_bus.re}, 32'h0);
    chk("midrst_m1_ready", {31'h0, m1_bus.ready}, 32'h0);
    chk("midrst_m1_rdata", m1_bus.rdata, 32'h0);
    to_pos();
    rst           = 1'b0;
    mem_bus.ready = 1'b1;
    m0_bus.re     = 1'b1;
    m0_bus.addr   = 32'h50;
    acc_q.push_back('{m: 1'b0, addr: 32'h50, we: 4'h0});
    push_wr(1'b1, 32'h24);
    @(negedge clk);
    chk("post_midrst_m0", {31'h0, m0_bus.ready}, 32'h1);
    to_pos();
    m0_bus.re = 1'b0;
    @(negedge clk);
    chk("post_midrst_m1", {31'h0, m1_bus.ready}, 32'h1);
    to_pos();
    m1_bus.we = 4'h0;
    idle();
    idle();

    chk("queue_drained", 32'(acc_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boa_mem_arbiter.md
Name: boa_mem_arbiter

Overview:
- Two-master to one-slave arbiter for the boa memory bus.
- Sits directly upstream of block_ram (or any boa_mem_bus.MEM slave) and lets two requesters share one RAM, e.g. instruction fetch and data port.
- Round-robin with bounded bursts and grant locking while a transfer is stalled.
- Routes the one-cycle-delayed read data back to the master that issued the read.

Parameters:
- burst_max, 4: max consecutive accepted transfers for one master while the other is requesting; legal range 1..15.

Ports:
- clk  input  1  memory clock.
- rst  input  1  asynchronous, active-high reset.
- m0  boa_mem_bus.MEM  interface  master 0 (higher priority after reset); re, we[3:0], addr[31:0], wdata[31:0], rdata[31:0], ready.
- m1  boa_mem_bus.MEM  interface  master 1; same signals.
- mem  boa_mem_bus.CPU  interface  downstream slave port.

Behaviour:
- Bus semantics:
  - A master requests when re=1 or we!=0.
  - A request is accepted in a cycle with ready=1.
  - Read data is valid on rdata in the cycle after acceptance.
  - The master holds its request stable until ready=1.
- Per-master request: req_i = m_i.re | (|m_i.we).
- State:
  - owner (1 bit): last granted master.
  - cnt: consecutive accepts by owner, width $clog2(burst_max+1), saturating at burst_max.
  - lock (1 bit).
  - resp_sel (1 bit).
- Grant (combinational), in order:
  - lock=1: grant=owner.
  - Only one req: grant it.
  - Both req: grant=owner if cnt<burst_max, else the other master.
  - No req: no grant.
- Forwarding:
  - mem.re/we/addr/wdata come from the granted master.
  - With no grant: mem.re=0, mem.we=0, and addr/wdata hold the owner's values.
  - mem.ready goes to the granted master only; the non-granted master sees ready=0.
- Handshake (grant valid and mem.ready=1):
  - owner <= grant.
  - cnt <= (grant==owner) ? sat(cnt+1) : 1.
  - lock <= 0.
- Stall (grant valid and mem.ready=0): lock <= 1 and owner <= grant. The grant cannot change mid-transfer.
- Idle (no req): cnt <= 0; owner unchanged.
- Response routing:
  - On an accepted read, resp_sel <= grant.
  - m[resp_sel].rdata = mem.rdata; the other master's rdata = 0.
  - resp_sel is held when the cycle accepts no read.
- Throughput: zero added latency. With block_ram (ready=1) the arbiter sustains one transfer per cycle and switches masters back-to-back with no bubble.
- Simultaneous events: both masters requesting on the first cycle after reset grants m0 (owner=0, cnt=0).
- Reset, asynchronous, immediate regardless of in-flight transfer:
  - owner=0, cnt=0, lock=0, resp_sel=0.
  - While rst=1: mem.re=0, mem.we=0, m0.ready=m1.ready=0, m0.rdata=m1.rdata=0.
  - A request cut by reset is not replayed; the master must re-present it.
- Write with re=0: resp_sel is unchanged.

Optional Feature:
- Macro BOA_MEM_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority, m0 always wins a contest; burst_max and cnt are ignored.
  - lock still holds m1's grant while m1 is stalled.
- Undefined: round-robin with burst limit as above.

Decomposition:
- Package boa_mem_arb_pkg: arb_sel_t (1-bit master index); function cnt_width(burst_max).
- One combinational sub-module, boa_mem_arb_grant: inputs req0, req1, owner, cnt, lock; outputs grant_valid, grant. It is unit-testable in isolation.
- The top level holds the registers and the interface muxing.

Test Plan:
- Reset state: rst=1 with m0.re=1, addr=0x10 -> mem.re=0, m0.ready=0. Release rst -> next cycle mem.addr=0x10, m0.ready=1; following cycle m0.rdata=RAM[4], m1.rdata=0.
- Contention with burst_max=4: both masters issue continuous reads -> accept order m0,m0,m0,m0,m1,m1,m1,m1,m0…; each rdata returns to its issuer one cycle later.
- Stall lock: slave model holds ready=0 for 3 cycles on m1 write (we=4'hF, addr=0x20, wdata=0xDEADBEEF) while m0 requests -> mem signals stay on m1 all 3 cycles; m0 accepted the cycle after m1's ready.
- Idle reset of cnt: m0 does 3 reads, idles 1 cycle, then both request -> m0 gets 4 more before m1 is granted.
- Mid-transfer reset: assert rst during m1 stalled write -> mem.we=0 within the same cycle; after release owner=0, and a simultaneous request grants m0 first.
- With BOA_MEM_ARB_FIXED_PRIO_EN: both masters request continuously -> m1 is never granted; once m0 drops re, m1 is accepted next cycle.
